// File: rtl/tetris_game_sequencer_if.sv
// Bus between the Tetris game sequencer and its environment:
// control pulses and map collision flags go in, piece pose and map strobes come out.
interface tetris_game_sequencer_if #(
  parameter int unsigned LINES_W = 16
);
  logic               start;
  logic               tick;
  logic               btn_left;
  logic               btn_right;
  logic               btn_rot;
  logic               btn_drop;
  logic               blk_down;
  logic               blk_left;
  logic               blk_right;
  logic               blk_rot;
  logic               spawn_blocked;
  logic               full_row;
  logic [2:0]         piece_id;
  logic [3:0]         piece_x;
  logic [4:0]         piece_y;
  logic [1:0]         piece_rot;
  logic               commit;
  logic               shift_row;
  logic [LINES_W-1:0] lines;
  logic               game_over;
  logic [3:0]         state;

  // Sequencer side
  modport master (
    input  start, tick, btn_left, btn_right, btn_rot, btn_drop,
    input  blk_down, blk_left, blk_right, blk_rot, spawn_blocked, full_row,
    output piece_id, piece_x, piece_y, piece_rot,
    output commit, shift_row, lines, game_over, state
  );

  // Input/timer logic and map storage side
  modport slave (
    output start, tick, btn_left, btn_right, btn_rot, btn_drop,
    output blk_down, blk_left, blk_right, blk_rot, spawn_blocked, full_row,
    input  piece_id, piece_x, piece_y, piece_rot,
    input  commit, shift_row, lines, game_over, state
  );
endinterface

// File: rtl/tetris_game_sequencer.sv
// Tetris game sequencer: owns the falling piece pose, applies gravity and player
// moves against map collision flags, and steps each piece through commit,
// row collapse and respawn. Optional macro TETRIS_SEQ_RANDOM_EN selects an
// 8-bit LFSR piece generator instead of the cyclic 0..6 counter.
module tetris_game_sequencer #(
  parameter int unsigned SPAWN_X = 4,
  parameter int unsigned LINES_W = 16
) (
  input logic                     clk,
  input logic                     rst,
  tetris_game_sequencer_if.master bus
);

  localparam int unsigned X_MAX = 9;
  localparam int unsigned Y_MAX = 19;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    SPAWN  = 4'd1,
    CHECK  = 4'd2,
    FALL   = 4'd3,
    DROP   = 4'd4,
    LOCK   = 4'd5,
    SETTLE = 4'd6,
    CLEAR  = 4'd7,
    OVER   = 4'd8
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         id_q, id_d;
  logic [3:0]         x_q, x_d;
  logic [4:0]         y_q, y_d;
  logic [1:0]         rot_q, rot_d;
  logic [LINES_W-1:0] lines_q, lines_d;
  logic [2:0]         gen_id;
  logic               stop_down, stop_left, stop_right;

`ifdef TETRIS_SEQ_RANDOM_EN
  logic [7:0] lfsr_q;

  // Free-running Fibonacci LFSR, x^8+x^6+x^5+x^4+1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 8'h01;
    else     lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign gen_id = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
`else
  logic [2:0] seq_q;

  // Cyclic 0..6 piece counter, advancing once per spawn
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  seq_q <= 3'd0;
    else if (state_q == SPAWN) seq_q <= (seq_q == 3'd6) ? 3'd0 : seq_q + 3'd1;
  end

  assign gen_id = seq_q;
`endif

  // Wall and floor safeguards on top of the map's collision flags
  assign stop_down  = bus.blk_down  | (y_q == 5'(Y_MAX));
  assign stop_left  = bus.blk_left  | (x_q == 4'd0);
  assign stop_right = bus.blk_right | (x_q == 4'(X_MAX));

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= 3'd0;
      x_q     <= 4'd0;
      y_q     <= 5'd0;
      rot_q   <= 2'd0;
      lines_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rot_q   <= rot_d;
      lines_q <= lines_d;
    end
  end

  // Next-state and next-pose decode
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    x_d     = x_q;
    y_d     = y_q;
    rot_d   = rot_q;
    lines_d = lines_q;
    case (state_q)
      IDLE, OVER: begin
        if (bus.start) begin
          lines_d = '0;
          state_d = SPAWN;
        end
      end
      SPAWN: begin
        x_d     = 4'(SPAWN_X);
        y_d     = 5'd0;
        rot_d   = 2'd0;
        id_d    = gen_id;
        state_d = CHECK;
      end
      CHECK:  state_d = bus.spawn_blocked ? OVER : FALL;
      FALL: begin
        if (bus.tick) begin
          if (stop_down) state_d = LOCK;
          else           y_d = y_q + 5'd1;
        end else if (bus.btn_drop) begin
          state_d = DROP;
        end else if (bus.btn_rot) begin
          if (!bus.blk_rot) rot_d = rot_q + 2'd1;
        end else if (bus.btn_left) begin
          if (!stop_left) x_d = x_q - 4'd1;
        end else if (bus.btn_right) begin
          if (!stop_right) x_d = x_q + 4'd1;
        end
      end
      DROP: begin
        if (stop_down) state_d = LOCK;
        else           y_d = y_q + 5'd1;
      end
      LOCK:   state_d = SETTLE;
      SETTLE: state_d = CLEAR;
      CLEAR: begin
        if (bus.full_row) begin
          if (lines_q != '1) lines_d = lines_q + LINES_W'(1);
          state_d = SETTLE;
        end else begin
          state_d = SPAWN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.piece_id  = id_q;
  assign bus.piece_x   = x_q;
  assign bus.piece_y   = y_q;
  assign bus.piece_rot = rot_q;
  assign bus.lines     = lines_q;
  assign bus.state     = state_q;
  assign bus.commit    = (state_q == LOCK);
  assign bus.shift_row = (state_q == CLEAR) & bus.full_row;
  assign bus.game_over = (state_q == OVER);

endmodule
